coproc_cmd_sched: RTL and testbench

- Command scheduler between the CPU's memory-mapped I/O space and the image coprocessor.
- The CPU writes coprocessor commands into a small in-order FIFO.
- The scheduler issues one command at a time using a start/done handshake.
- It publishes busy/done status, which the top level exports as the coprocessor status bits (bit 1 = done), plus a readable status word and a completion interrupt.

---
 rtl/coproc_cmd_sched.sv | 175 +++++++++++++++++
 tb/tb_coproc_cmd_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coproc_cmd_sched.sv
// rtl/coproc_cmd_sched.sv - in-order command FIFO and start/done scheduler for the image coprocessor
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   mmio_wr, mmio_rd      CPU write/read strobes
//   mmio_addr             0 = CMD, 1 = STATUS, 2 = CTRL
//   mmio_wdata            write data; CMD = {arg, op}
//   mmio_rdata            registered read data (holds when not reading)
//   cp_start              one-cycle start pulse; cp_op/cp_arg valid from here until cp_done
//   cp_op, cp_arg         command being executed
//   cp_done               one-cycle completion pulse from the coprocessor
//   cp_abort              one-cycle abort pulse on watchdog expiry
//   coproc_sts            {done, busy}
//   irq                   one-cycle pulse per completion
//
// Optional feature: define COPROC_TIMEOUT_EN to enable the WAIT-state watchdog.
module coproc_cmd_sched #(
  parameter int OP_W        = 4,
  parameter int ARG_W       = 28,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mmio_wr,
  input  logic             mmio_rd,
  input  logic [1:0]       mmio_addr,
  input  logic [31:0]      mmio_wdata,
  output logic [31:0]      mmio_rdata,
  output logic             cp_start,
  output logic [OP_W-1:0]  cp_op,
  output logic [ARG_W-1:0] cp_arg,
  input  logic             cp_done,
  output logic             cp_abort,
  output logic [1:0]       coproc_sts,
  output logic             irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t state, state_nxt;

  logic [OP_W+ARG_W-1:0] mem [FIFO_DEPTH];
  logic [OP_W+ARG_W-1:0] head;
  logic [PTR_W:0]        wr_ptr, rd_ptr, occ;
  logic [2:0]            occ_disp;
  logic                  empty, full, busy;
  logic                  done, ovf, tmo;
  logic [7:0]            cmp_cnt;
  logic [31:0]           status_word;

  logic cmd_wr, ctrl_wr, flush, push, pop, ovf_set, wait_done, tmo_hit;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign occ   = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  assign cmd_wr  = mmio_wr && (mmio_addr == ADDR_CMD);
  assign ctrl_wr = mmio_wr && (mmio_addr == ADDR_CTRL);
  assign flush   = ctrl_wr && mmio_wdata[1];
  // Full is judged before any same-cycle pop; a flush discards the push outright.
  assign push    = cmd_wr && !full && !flush;
  assign ovf_set = cmd_wr && full && !flush;
  assign pop     = (state == S_ISSUE);
  assign wait_done = (state == S_WAIT) && cp_done;

  assign busy       = (state != S_IDLE) || !empty;
  assign coproc_sts = {done, busy};
  assign occ_disp   = (int'(occ) > 7) ? 3'd7 : 3'(occ);
  assign status_word = {8'd0, cmp_cnt, 7'd0, occ_disp, tmo, ovf, empty, full, done, busy};

  always_comb begin
    state_nxt = state;
    case (state)
      // A flush in the same cycle empties the FIFO, so do not start issuing from it.
      S_IDLE:  if (!empty && !flush) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (cp_done || tmo_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= mmio_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cp_start   <= 1'b0;
      cp_op      <= '0;
      cp_arg     <= '0;
      irq        <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      cmp_cnt    <= 8'd0;
      mmio_rdata <= 32'd0;
    end else begin
      state <= state_nxt;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end

      // Command registers load on entry to ISSUE, so they are valid with cp_start.
      cp_start <= (state_nxt == S_ISSUE);
      if (state_nxt == S_ISSUE) begin
        cp_op  <= head[OP_W-1:0];
        cp_arg <= head[OP_W +: ARG_W];
      end

      irq <= wait_done;
      if (wait_done)
        done <= 1'b1;
      else if ((state == S_ISSUE) || (ctrl_wr && mmio_wdata[0]))
        done <= 1'b0;

      if (wait_done) cmp_cnt <= cmp_cnt + 8'd1;

      if (ctrl_wr && mmio_wdata[2])
        ovf <= 1'b0;
      else if (ovf_set)
        ovf <= 1'b1;

      if (mmio_rd)
        mmio_rdata <= (mmio_addr == ADDR_STATUS) ? status_word : 32'd0;
    end
  end

`ifdef COPROC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Expires on the TIMEOUT_CYC-th WAIT cycle unless cp_done arrives in it.
  assign tmo_hit = (state == S_WAIT) && !cp_done && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt  <= '0;
      cp_abort <= 1'b0;
      tmo      <= 1'b0;
    end else begin
      cp_abort <= tmo_hit;
      if (state == S_ISSUE)
        tmo_cnt <= '0;
      else if (state == S_WAIT)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (ctrl_wr && mmio_wdata[2])
        tmo <= 1'b0;
      else if (tmo_hit)
        tmo <= 1'b1;
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC > 0);
  assign tmo_hit  = 1'b0;
  assign cp_abort = 1'b0;
  assign tmo      = 1'b0;
`endif

endmodule

// File: tb/tb_coproc_cmd_sched.sv
// tb/tb_coproc_cmd_sched.sv - directed scoreboard bench for coproc_cmd_sched
module tb_coproc_cmd_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mmio_wr, mmio_rd;
  logic [1:0]  mmio_addr;
  logic [31:0] mmio_wdata, mmio_rdata;
  logic        cp_start, cp_done, cp_abort, irq;
  logic [3:0]  cp_op;
  logic [27:0] cp_arg;
  logic [1:0]  coproc_sts;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int rd_idx = 0;
  int start_cnt = 0, irq_cnt = 0, done_rise = 0;
  logic done_prev = 1'b0;

  coproc_cmd_sched #(.OP_W(4), .ARG_W(28), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mmio_wr(mmio_wr), .mmio_rd(mmio_rd), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .cp_start(cp_start), .cp_op(cp_op), .cp_arg(cp_arg),
    .cp_done(cp_done), .cp_abort(cp_abort),
    .coproc_sts(coproc_sts), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cp_start) begin
      obs_q.push_back({cp_arg, cp_op});
      start_cnt++;
    end
    if (irq) irq_cnt++;
    if (coproc_sts[1] && !done_prev) done_rise++;
    done_prev = coproc_sts[1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mmio_write(input logic [1:0] a, input logic [31:0] d);
    mmio_wr = 1'b1; mmio_addr = a; mmio_wdata = d;
    tick();
    mmio_wr = 1'b0;
  endtask

  task automatic mmio_read(input logic [1:0] a, output logic [31:0] d);
    mmio_rd = 1'b1; mmio_addr = a;
    tick();
    mmio_rd = 1'b0;
    d = mmio_rdata;
  endtask

  task automatic pulse_done();
    cp_done = 1'b1;
    tick();
    cp_done = 1'b0;
  endtask

  task automatic push_cmd(input logic [31:0] d, input bit accepted);
    if (accepted) exp_q.push_back(d);
    mmio_write(2'd0, d);
  endtask

  task automatic sb_check(input string tag);
    logic [31:0] e;
    int budget = 0;
    while (obs_q.size() <= rd_idx && budget < 50) begin
      tick();
      budget++;
    end
    check({tag, "_start_seen"}, 32'(obs_q.size() > rd_idx), 32'd1);
    if (obs_q.size() > rd_idx && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, obs_q[rd_idx], e);
      rd_idx++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    int s0, i0, r0;

    rst_n = 1'b0; mmio_wr = 1'b0; mmio_rd = 1'b0; mmio_addr = 2'd0;
    mmio_wdata = 32'd0; cp_done = 1'b0;
    tick(); tick();
    check("rst_sts", 32'(coproc_sts), 32'd0);
    check("rst_start", 32'(cp_start), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", mmio_rdata, 32'd0);
    rst_n = 1'b1;
    tick();
    mmio_read(2'd1, rd);
    check("rst_status", rd, 32'h0000_0008);

    // single command, start latency and completion
    push_cmd(32'h0000_0123, 1'b1);
    check("lat_idle", 32'(cp_start), 32'd0);
    tick();
    check("lat_start", 32'(cp_start), 32'd1);
    check("lat_op", 32'(cp_op), 32'h3);
    check("lat_arg", 32'(cp_arg), 32'h12);
    sb_check("cmd1");
    check("start_one_cycle", 32'(cp_start), 32'd0);
    repeat (8) tick();
    i0 = irq_cnt;
    pulse_done();
    check("cmp1_irq", 32'(irq), 32'd1);
    check("cmp1_sts", 32'(coproc_sts), 32'h2);
    tick();
    check("cmp1_irq_low", 32'(irq), 32'd0);
    tick();
    check("cmp1_irq_cnt", 32'(irq_cnt - i0), 32'd1);
    mmio_read(2'd1, rd);
    check("cmp1_status", rd, 32'h0001_000A);
    tick(); tick();
    check("rdata_hold", mmio_rdata, 32'h0001_000A);
    mmio_read(2'd0, rd);
    check("rd_cmd_zero", rd, 32'd0);

    // overflow: 6 writes while stalled, 1 issued + 4 queued + 1 dropped
    do_reset();
    s0 = start_cnt; i0 = irq_cnt; r0 = done_rise;
    for (int i = 0; i < 6; i++)
      push_cmd({28'(32'h0AB0 + i * 32'h111), 4'(i + 4)}, i < 5);
    mmio_read(2'd1, rd);
    check("ovf_status", rd, 32'h0000_0115);
    for (int k = 0; k < 5; k++) begin
      sb_check("burst");
      tick(); tick();
      pulse_done();
      if (k < 4) begin
        check("b2b_gap", 32'(cp_start), 32'd0);
        tick();
        check("b2b_start", 32'(cp_start), 32'd1);
      end
    end
    tick(); tick();
    check("burst_starts", 32'(start_cnt - s0), 32'd5);
    check("burst_irqs", 32'(irq_cnt - i0), 32'd5);
    check("burst_done_rises", 32'(done_rise - r0), 32'd5);
    mmio_read(2'd1, rd);
    check("burst_status", rd, 32'h0005_001A);

    // flush with one in flight, then clear OVF
    s0 = start_cnt; i0 = irq_cnt;
    for (int i = 0; i < 4; i++)
      push_cmd({28'(32'h5500 + i), 4'hA}, i == 0);
    mmio_write(2'd2, 32'h2);
    mmio_read(2'd1, rd);
    check("flush_status", rd, 32'h0005_0019);
    sb_check("flush_inflight");
    pulse_done();
    check("flush_irq", 32'(irq), 32'd1);
    repeat (6) tick();
    check("flush_starts", 32'(start_cnt - s0), 32'd1);
    check("flush_irqs", 32'(irq_cnt - i0), 32'd1);
    mmio_write(2'd2, 32'h4);
    mmio_read(2'd1, rd);
    check("ovf_clr_status", rd, 32'h0006_000A);

    // reset asserted mid-WAIT, stale cp_done afterwards
    push_cmd(32'h0000_0777, 1'b1);
    sb_check("pre_reset");
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_sts", 32'(coproc_sts), 32'd0);
    check("async_rst_op", {cp_arg, cp_op}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_done();
    check("stale_irq", 32'(irq), 32'd0);
    check("stale_sts", 32'(coproc_sts), 32'd0);
    mmio_read(2'd1, rd);
    check("stale_status", rd, 32'h0000_0008);

    // watchdog
    push_cmd(32'h0000_0ED9, 1'b1);
    tick();
    check("wd_start", 32'(cp_start), 32'd1);
    sb_check("wd_cmd");
`ifdef COPROC_TIMEOUT_EN
    repeat (15) tick();
    check("wd_abort_early", 32'(cp_abort), 32'd0);
    tick();
    check("wd_abort", 32'(cp_abort), 32'd1);
    check("wd_sts", 32'(coproc_sts), 32'd0);
    tick();
    check("wd_abort_pulse", 32'(cp_abort), 32'd0);
    mmio_read(2'd1, rd);
    check("wd_status", rd, 32'h0000_0028);
    mmio_write(2'd2, 32'h4);
    mmio_read(2'd1, rd);
    check("wd_clr_status", rd, 32'h0000_0008);
`else
    repeat (30) tick();
    check("nowd_abort", 32'(cp_abort), 32'd0);
    check("nowd_busy", 32'(coproc_sts), 32'h1);
    pulse_done();
    check("nowd_irq", 32'(irq), 32'd1);
    tick();
    mmio_read(2'd1, rd);
    check("nowd_status", rd, 32'h0001_000A);
`endif

    repeat (4) tick();
    check("sb_exp_drained", 32'(exp_q.size()), 32'd0);
    check("sb_no_extra_start", 32'(obs_q.size()), 32'(rd_idx));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
